// File: rtl/me_frame_loader_if.sv
// me_frame_loader_if: pixel stream, engine memory-write, engine control and
// motion-vector result signals of the motion-estimation frame loader.
// master: the loader's view; slave: the surrounding system's view.
interface me_frame_loader_if;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [4:0]  address_write_cur;
  logic [63:0] data_write_cur;
  logic        write_enable_cur;
  logic [6:0]  address_write_ref;
  logic [63:0] data_write_ref;
  logic        write_enable_ref;
  logic        go;
  logic        done_in;
  logic [7:0]  m_i_in;
  logic [7:0]  m_j_in;
  logic [7:0]  mv_i;
  logic [7:0]  mv_j;
  logic        mv_valid;
  logic        mv_ready;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  pix_data, pix_valid, done_in, m_i_in, m_j_in, mv_ready,
    output pix_ready, address_write_cur, data_write_cur, write_enable_cur,
           address_write_ref, data_write_ref, write_enable_ref, go,
           mv_i, mv_j, mv_valid, busy, timeout_err
  );

  modport slave (
    output pix_data, pix_valid, done_in, m_i_in, m_j_in, mv_ready,
    input  pix_ready, address_write_cur, data_write_cur, write_enable_cur,
           address_write_ref, data_write_ref, write_enable_ref, go,
           mv_i, mv_j, mv_valid, busy, timeout_err
  );
endinterface

// File: rtl/me_frame_loader.sv
// me_frame_loader: packs a raster pixel stream (current block, then reference
// window) into 64-bit words, writes them into the engine memories, pulses go,
// then captures the engine's motion vector and offers it on a valid/ready port.
// Optional macro ME_LOAD_TIMEOUT_EN adds a watchdog on the wait for done_in.
module me_frame_loader #(
  parameter int PIX_W          = 8,
  parameter int PACK           = 8,
  parameter int CUR_WORDS      = 32,
  parameter int REF_WORDS      = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic              clk,
  input logic              reset,
  me_frame_loader_if.master ldr_if
);

  localparam int WORD_W = PIX_W * PACK;
  localparam int PART_W = WORD_W - PIX_W;
  localparam int CNT_W  = $clog2(PACK);
  localparam int CUR_AW = $clog2(CUR_WORDS);
  localparam int REF_AW = $clog2(REF_WORDS);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD_CUR = 3'd1;
  localparam logic [2:0] ST_LOAD_REF = 3'd2;
  localparam logic [2:0] ST_GO       = 3'd3;
  localparam logic [2:0] ST_WAIT     = 3'd4;
  localparam logic [2:0] ST_RESULT   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [PART_W-1:0] pack_q, pack_d;
  logic [REF_AW-1:0] word_cnt_q, word_cnt_d;
  logic              we_cur_q, we_cur_d, we_ref_q, we_ref_d;
  logic [CUR_AW-1:0] addr_cur_q, addr_cur_d;
  logic [REF_AW-1:0] addr_ref_q, addr_ref_d;
  logic [WORD_W-1:0] data_cur_q, data_cur_d, data_ref_q, data_ref_d;
  logic              go_q, go_d;
  logic              done_prev_q;
  logic [7:0]        mv_i_q, mv_i_d, mv_j_q, mv_j_d;
  logic              mv_valid_q, mv_valid_d;

  logic              loading_s, accept_s, last_pix_s, done_rise_s;
  logic [WORD_W-1:0] word_s;

`ifdef ME_LOAD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            tmo_q, tmo_d;
`else
  logic            unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
`endif

  assign loading_s   = (state_q == ST_IDLE) || (state_q == ST_LOAD_CUR) ||
                       (state_q == ST_LOAD_REF);
  assign accept_s    = ldr_if.pix_valid && ldr_if.pix_ready;
  assign last_pix_s  = (pix_cnt_q == CNT_W'(PACK - 1));
  // First pixel of a group ends up in the top byte, the last in the bottom byte.
  assign word_s      = {pack_q, ldr_if.pix_data};
  assign done_rise_s = ldr_if.done_in && !done_prev_q;

  // Next-state logic: packer, word counter, write strobes, FSM and result capture.
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    pack_d     = pack_q;
    word_cnt_d = word_cnt_q;
    we_cur_d   = 1'b0;
    we_ref_d   = 1'b0;
    addr_cur_d = addr_cur_q;
    addr_ref_d = addr_ref_q;
    data_cur_d = data_cur_q;
    data_ref_d = data_ref_q;
    go_d       = 1'b0;
    mv_i_d     = mv_i_q;
    mv_j_d     = mv_j_q;
    mv_valid_d = mv_valid_q;
`ifdef ME_LOAD_TIMEOUT_EN
    wd_cnt_d   = '0;
    tmo_d      = tmo_q;
`endif

    if (accept_s) begin
      if (last_pix_s) begin
        pix_cnt_d = '0;
        pack_d    = '0;
      end else begin
        pix_cnt_d = pix_cnt_q + 1'b1;
        pack_d    = {pack_q[PART_W-PIX_W-1:0], ldr_if.pix_data};
      end
    end else begin
      pix_cnt_d = pix_cnt_q;
    end

    case (state_q)
      ST_IDLE, ST_LOAD_CUR: begin
        if (accept_s && last_pix_s) begin
          we_cur_d   = 1'b1;
          addr_cur_d = word_cnt_q[CUR_AW-1:0];
          data_cur_d = word_s;
          if (word_cnt_q == REF_AW'(CUR_WORDS - 1)) begin
            // Next accepted pixel is reference pixel 0, no gap.
            word_cnt_d = '0;
            state_d    = ST_LOAD_REF;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = ST_LOAD_CUR;
          end
        end else if (accept_s) begin
          state_d = ST_LOAD_CUR;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_REF: begin
        if (accept_s && last_pix_s) begin
          we_ref_d   = 1'b1;
          addr_ref_d = word_cnt_q;
          data_ref_d = word_s;
          if (word_cnt_q == REF_AW'(REF_WORDS - 1)) begin
            word_cnt_d = '0;
            state_d    = ST_GO;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_LOAD_REF;
        end
      end
      ST_GO: begin
        // go is registered, so it is seen one cycle after the last ref write.
        go_d    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise_s) begin
          mv_i_d     = ldr_if.m_i_in;
          mv_j_d     = ldr_if.m_j_in;
          mv_valid_d = 1'b1;
          state_d    = ST_RESULT;
        end else begin
`ifdef ME_LOAD_TIMEOUT_EN
          if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            mv_i_d     = 8'hFF;
            mv_j_d     = 8'hFF;
            mv_valid_d = 1'b1;
            tmo_d      = 1'b1;
            state_d    = ST_RESULT;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_RESULT: begin
        if (mv_valid_q && ldr_if.mv_ready) begin
          mv_valid_d = 1'b0;
`ifdef ME_LOAD_TIMEOUT_EN
          tmo_d      = 1'b0;
`endif
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      pack_q      <= '0;
      word_cnt_q  <= '0;
      we_cur_q    <= 1'b0;
      we_ref_q    <= 1'b0;
      addr_cur_q  <= '0;
      addr_ref_q  <= '0;
      data_cur_q  <= '0;
      data_ref_q  <= '0;
      go_q        <= 1'b0;
      done_prev_q <= 1'b0;
      mv_i_q      <= 8'h00;
      mv_j_q      <= 8'h00;
      mv_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      pack_q      <= pack_d;
      word_cnt_q  <= word_cnt_d;
      we_cur_q    <= we_cur_d;
      we_ref_q    <= we_ref_d;
      addr_cur_q  <= addr_cur_d;
      addr_ref_q  <= addr_ref_d;
      data_cur_q  <= data_cur_d;
      data_ref_q  <= data_ref_d;
      go_q        <= go_d;
      done_prev_q <= ldr_if.done_in;
      mv_i_q      <= mv_i_d;
      mv_j_q      <= mv_j_d;
      mv_valid_q  <= mv_valid_d;
    end
  end

`ifdef ME_LOAD_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      tmo_q    <= tmo_d;
    end
  end
  assign ldr_if.timeout_err = tmo_q;
`else
  assign ldr_if.timeout_err = 1'b0;
`endif

  // pix_ready is forced low while reset is asserted so all outputs read 0.
  assign ldr_if.pix_ready         = !reset && loading_s;
  assign ldr_if.busy              = (state_q != ST_IDLE);
  assign ldr_if.write_enable_cur  = we_cur_q;
  assign ldr_if.address_write_cur = addr_cur_q;
  assign ldr_if.data_write_cur    = data_cur_q;
  assign ldr_if.write_enable_ref  = we_ref_q;
  assign ldr_if.address_write_ref = addr_ref_q;
  assign ldr_if.data_write_ref    = data_ref_q;
  assign ldr_if.go                = go_q;
  assign ldr_if.mv_i              = mv_i_q;
  assign ldr_if.mv_j              = mv_j_q;
  assign ldr_if.mv_valid          = mv_valid_q;

endmodule

// File: tb/tb_me_frame_loader.sv
// tb_me_frame_loader: directed bench for me_frame_loader. Streams 0x00..0xFF
// cyclically, records memory writes, and checks words, counts, go timing,
// result capture/handshake, reset abort and (with ME_LOAD_TIMEOUT_EN) the
// watchdog with TIMEOUT_CYCLES = 16.
module tb_me_frame_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  me_frame_loader_if bus();

  me_frame_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .ldr_if (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  localparam logic [63:0] SENTINEL = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        mon_clr = 1'b0;
  logic [63:0] cur_mem [32];
  logic [63:0] ref_mem [128];
  int          cur_wr = 0, ref_wr = 0, go_cnt = 0, last_ref_cyc = 0, go_cyc = 0;

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Write/go monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_clr) begin
      for (int i = 0; i < 32; i++) cur_mem[i] <= SENTINEL;
      for (int i = 0; i < 128; i++) ref_mem[i] <= SENTINEL;
      cur_wr <= 0;
      ref_wr <= 0;
      go_cnt <= 0;
    end else if (!reset) begin
      if (bus.write_enable_cur) begin
        cur_mem[bus.address_write_cur] <= bus.data_write_cur;
        cur_wr <= cur_wr + 1;
      end
      if (bus.write_enable_ref) begin
        ref_mem[bus.address_write_ref] <= bus.data_write_ref;
        ref_wr <= ref_wr + 1;
        last_ref_cyc <= cyc;
      end
      if (bus.go) begin
        go_cnt <= go_cnt + 1;
        go_cyc <= cyc;
      end
    end
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected packed word whose first pixel is stream index base.
  function automatic logic [63:0] exp_word(input int base);
    logic [63:0] e;
    e = 64'h0;
    for (int k = 0; k < 8; k++) e = {e[55:0], 8'((base + k) % 256)};
    return e;
  endfunction

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit rnd);
    int sent = 0;
    int budget = 0;
    while (sent < n && budget < n * 6 + 100) begin
      @(negedge clk);
      budget++;
      bus.pix_data  = 8'(sent % 256);
      bus.pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.pix_valid && bus.pix_ready) sent++;
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    if (sent != n) check_vec("stream_budget", 64'(sent), 64'(n));
  endtask

  // Ends on the falling edge of the first cycle with go high.
  task automatic wait_go();
    int t = 0;
    while (!bus.go && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_vec("go_seen", 64'(bus.go), 64'd1);
  endtask

  task automatic check_load(input string tag);
    @(negedge clk);
    check_vec({tag, "_cur_wr"}, 64'(cur_wr), 64'd32);
    check_vec({tag, "_ref_wr"}, 64'(ref_wr), 64'd128);
    check_vec({tag, "_go_cnt"}, 64'(go_cnt), 64'd1);
    check_vec({tag, "_go_lag"}, 64'(go_cyc - last_ref_cyc), 64'd1);
    check_vec({tag, "_cur0"}, cur_mem[0], 64'h0001020304050607);
    check_vec({tag, "_cur31"}, cur_mem[31], 64'hF8F9FAFBFCFDFEFF);
    check_vec({tag, "_ref0"}, ref_mem[0], 64'h0001020304050607);
    for (int w = 0; w < 32; w++)
      check_vec($sformatf("%s_cur[%0d]", tag, w), cur_mem[w], exp_word(8 * w));
    for (int w = 0; w < 128; w++)
      check_vec($sformatf("%s_ref[%0d]", tag, w), ref_mem[w], exp_word(256 + 8 * w));
  endtask

  task automatic check_zero(input string tag);
    check_vec({tag, "_ctl"}, {57'h0, bus.pix_ready, bus.write_enable_cur, bus.write_enable_ref,
                              bus.go, bus.mv_valid, bus.busy, bus.timeout_err}, 64'h0);
    check_vec({tag, "_addr"}, {52'h0, bus.address_write_cur, bus.address_write_ref}, 64'h0);
    check_vec({tag, "_dcur"}, bus.data_write_cur, 64'h0);
    check_vec({tag, "_dref"}, bus.data_write_ref, 64'h0);
    check_vec({tag, "_mv"}, {48'h0, bus.mv_i, bus.mv_j}, 64'h0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.pix_data  = 8'h00;
    bus.pix_valid = 1'b0;
    bus.done_in   = 1'b0;
    bus.m_i_in    = 8'h00;
    bus.m_j_in    = 8'h00;
    bus.mv_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_vec("idle_ready", {62'h0, bus.pix_ready, bus.busy}, 64'h2);

    // Run 1: continuous stream, then done after 10 idle cycles.
    clear_mon();
    send_pixels(1280, 1'b0);
    wait_go();
    check_load("run1");
    check_vec("wait_ready_busy", {62'h0, bus.pix_ready, bus.busy}, 64'h1);
    repeat (10) @(negedge clk);
    check_vec("wait_no_valid", 64'(bus.mv_valid), 64'd0);
    bus.m_i_in  = 8'h03;
    bus.m_j_in  = 8'hFD;
    bus.done_in = 1'b1;
    @(negedge clk);
    check_vec("mv_capture", {47'h0, bus.mv_valid, bus.mv_i, bus.mv_j}, {47'h0, 1'b1, 16'h03FD});
    bus.m_i_in = 8'h55;
    bus.m_j_in = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_vec("mv_hold", {47'h0, bus.mv_valid, bus.mv_i, bus.mv_j}, {47'h0, 1'b1, 16'h03FD});
    end
    bus.mv_ready = 1'b1;
    @(negedge clk);
    bus.mv_ready = 1'b0;
    check_vec("mv_release", {62'h0, bus.mv_valid, bus.busy}, 64'h0);

    // Run 2: random 50% pix_valid; done_in still high from run 1.
    clear_mon();
    send_pixels(1280, 1'b1);
    wait_go();
    check_load("run2");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_vec("stale_done", 64'(bus.mv_valid), 64'd0);
    end
    bus.done_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.m_i_in   = 8'h12;
    bus.m_j_in   = 8'h34;
    bus.mv_ready = 1'b1;
    bus.done_in  = 1'b1;
    @(negedge clk);
    check_vec("mv_capture2", {47'h0, bus.mv_valid, bus.mv_i, bus.mv_j}, {47'h0, 1'b1, 16'h1234});
    @(negedge clk);
    check_vec("mv_one_cycle", {62'h0, bus.mv_valid, bus.busy}, 64'h0);
    bus.mv_ready = 1'b0;
    bus.done_in  = 1'b0;

    // Run 3: reset after 700 pixels, then a fresh full load.
    clear_mon();
    send_pixels(700, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_zero("abort");
    reset = 1'b0;
    clear_mon();
    send_pixels(1280, 1'b0);
    wait_go();
`ifdef ME_LOAD_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_vec("wd_pending", 64'(bus.mv_valid), 64'd0);
    end
    @(negedge clk);
    check_vec("wd_fire", {46'h0, bus.mv_valid, bus.timeout_err, bus.mv_i, bus.mv_j},
              {46'h0, 1'b1, 1'b1, 16'hFFFF});
    bus.mv_ready = 1'b1;
    @(negedge clk);
    bus.mv_ready = 1'b0;
    check_vec("wd_clear", {61'h0, bus.mv_valid, bus.timeout_err, bus.busy}, 64'h0);
`else
    repeat (40) @(negedge clk);
    check_vec("no_wd", {61'h0, bus.mv_valid, bus.timeout_err, bus.busy}, 64'h1);
    bus.m_i_in   = 8'h7F;
    bus.m_j_in   = 8'h80;
    bus.mv_ready = 1'b1;
    bus.done_in  = 1'b1;
    @(negedge clk);
    check_vec("mv_capture3", {47'h0, bus.mv_valid, bus.mv_i, bus.mv_j}, {47'h0, 1'b1, 16'h7F80});
    @(negedge clk);
    bus.mv_ready = 1'b0;
    bus.done_in  = 1'b0;
    check_vec("mv_release3", {62'h0, bus.mv_valid, bus.busy}, 64'h0);
`endif
    check_load("run3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/me_frame_loader.md
Name: me_frame_loader

Overview:
- Upstream feeder and result collector for the motion-estimation engine.
- Accepts a raster pixel stream (current block, then reference search window) and packs each group of 8 pixels into one 64-bit word.
- Writes the packed words into the engine's current (32 x 64) and reference (128 x 64) memories, then pulses `go`.
- Waits for the engine's `done`, captures `m_i`/`m_j`, and presents them on a valid/ready result port.

Parameters:
- PIX_W, 8: pixel width in bits.
- PACK, 8: pixels per memory word (word width = PIX_W*PACK = 64).
- CUR_WORDS, 32: current-block words (16x16 pixels).
- REF_WORDS, 128: reference-window words (32x32 pixels).
- TIMEOUT_CYCLES, 4096: watchdog limit; used only with ME_LOAD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock. The engine's clk_write must be tied to this clock.
- reset  in  1  synchronous, active-high reset.
- pix_data  in  8  pixel byte.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  loader accepts a pixel this cycle.
- address_write_cur  out  5  current-memory write address.
- data_write_cur  out  64  current-memory write data.
- write_enable_cur  out  1  current-memory write strobe.
- address_write_ref  out  7  reference-memory write address.
- data_write_ref  out  64  reference-memory write data.
- write_enable_ref  out  1  reference-memory write strobe.
- go  out  1  one-cycle engine start pulse.
- done_in  in  1  engine done.
- m_i_in  in  8  engine motion vector, i component.
- m_j_in  in  8  engine motion vector, j component.
- mv_i  out  8  captured i component.
- mv_j  out  8  captured j component.
- mv_valid  out  1  result valid.
- mv_ready  in  1  result consumer ready.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  watchdog fired (tied 0 without the macro).

Behaviour:
- Reset values: every output is 0; state = IDLE; pixel, word and watchdog counters = 0; any partial word is discarded. Reset mid-load or mid-wait aborts immediately.
- A pixel transfer occurs when pix_valid && pix_ready.
  - pix_ready = 1 in IDLE, LOAD_CUR and LOAD_REF; 0 otherwise.
- Packing is MSB-first: the first pixel of a group goes to bits [63:56], the 8th to [7:0].
- Write timing: the cycle after the 8th pixel of a group is accepted, the corresponding write_enable is high for exactly 1 cycle.
  - Data is the packed word; address is the word count (0..31 for cur, 0..127 for ref).
  - The word counter increments after each write and wraps to 0 on switching region.
  - Address and data outputs hold their last values when write_enable is low.
- State machine:
  - IDLE: the first accepted pixel goes into the cur packer -> LOAD_CUR.
  - LOAD_CUR: the 32nd cur word write -> LOAD_REF. The next accepted pixel is ref pixel 0; no gap is required.
  - LOAD_REF: the 128th ref word write -> GO.
  - GO: go = 1 for one cycle -> WAIT. Total load = 1280 pixels.
  - WAIT: capture on a done_in rising edge (done_in=1 and the registered previous value=0). A done_in held high from an earlier run is ignored.
    - On capture: mv_i <= m_i_in, mv_j <= m_j_in -> RESULT.
  - RESULT: mv_valid = 1. mv_i/mv_j stay stable until mv_valid && mv_ready. The following cycle mv_valid = 0 -> IDLE.
    - If mv_ready is already high on entry, mv_valid lasts exactly 1 cycle.
- Pixel stalls (pix_valid low) are allowed anywhere; the packer holds its state.
- busy = (state != IDLE).

Optional Feature:
- Macro: ME_LOAD_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT.
  - After TIMEOUT_CYCLES cycles with no done_in rising edge: mv_i = mv_j = 8'hFF, timeout_err = 1, -> RESULT.
  - timeout_err clears on the mv handshake or on reset.
- Undefined:
  - No counter.
  - WAIT lasts indefinitely.
  - timeout_err is constant 0.

Test Plan:
- Reset, then stream pixels 0x00..0xFF cyclically for 1280 beats with pix_valid held high.
  - cur word 0 = 64'h0001020304050607 at address 0.
  - cur word 31 = 64'hF8F9FAFBFCFDFEFF.
  - ref word 0 = 64'h0001020304050607 at address 0.
  - Exactly 32 cur writes and 128 ref writes.
  - go pulses once, 1 cycle after the final ref write.
- Same stream with pix_valid toggled randomly at 50% -> identical memory contents and write counts; no pixel lost or duplicated.
- After go, hold done_in=0 for 10 cycles, then raise it with m_i_in=8'h03, m_j_in=8'hFD.
  - mv_valid rises with mv_i=3, mv_j=8'hFD.
  - Hold mv_ready=0 for 5 cycles -> mv_valid and the data stay stable; a ready pulse returns to IDLE.
- done_in held high before go -> no capture until done_in falls and rises again.
- Assert reset after 700 pixels.
  - Outputs return to 0 and state to IDLE.
  - A fresh 1280-pixel load then writes cur from address 0.
- With ME_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=16, never assert done_in.
  - After 16 cycles in WAIT: mv_valid=1, mv_i=mv_j=8'hFF, timeout_err=1.
  - timeout_err clears after the handshake.
